// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry-kind encodings for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH     = 8;
  localparam int ROB_WIDTH_BIT = 3;
  localparam int REG_ID_BIT    = 5;

  typedef enum logic [1:0] {
    ROB_KIND_ALU    = 2'd0,
    ROB_KIND_BRANCH = 2'd1,
    ROB_KIND_JALR   = 2'd2
  } rob_kind_e;

  function automatic logic [31:0] branch_redirect(input logic taken,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags on issue, collects out-of-order
// results, retires one entry per cycle and resolves branches/jalr at commit.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_kind,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic [31:0]              issue_pc,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_target,
  output logic [ROB_WIDTH_BIT-1:0] issue_tag,
  output logic                     full,
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_tag,
  input  logic [31:0]              wb_value,
  input  logic [31:0]              wb_new_pc,
  input  logic [ROB_WIDTH_BIT-1:0] q_tag,
  output logic                     q_ready,
  output logic [31:0]              q_value,
  output logic                     commit_valid,
  output logic [ROB_WIDTH_BIT-1:0] commit_tag,
  output logic [REG_ID_BIT-1:0]    commit_rd,
  output logic [31:0]              commit_value,
  output logic                     flush,
  output logic [31:0]              flush_pc
);

  localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = (ROB_WIDTH_BIT+1)'(ROB_WIDTH);

  logic [ROB_WIDTH_BIT-1:0] head, tail;
  logic [ROB_WIDTH_BIT:0]   count;
  logic [ROB_WIDTH-1:0]     busy, ready, pred;

  rob_kind_e             kind   [ROB_WIDTH];
  logic [REG_ID_BIT-1:0] rd     [ROB_WIDTH];
  logic [31:0]           pc     [ROB_WIDTH];
  logic [31:0]           target [ROB_WIDTH];
  logic [31:0]           value  [ROB_WIDTH];
  logic [31:0]           new_pc [ROB_WIDTH];

  logic        commit_now, flush_now, issue_fire, wb_fire, taken;
  logic [31:0] redirect_pc;

  assign issue_tag = tail;
  assign full      = (count == FULL_COUNT);
  assign q_ready   = busy[q_tag] && ready[q_tag];
  assign q_value   = value[q_tag];

  // Readiness is registered, so a result written this cycle retires next cycle.
  assign commit_now = rdy_in && busy[head] && ready[head];
  assign taken      = value[head][0];
  assign issue_fire = rdy_in && issue_valid && !full && !flush_now;
  assign wb_fire    = rdy_in && wb_valid && busy[wb_tag] && !flush_now;

  always_comb begin
    flush_now   = 1'b0;
    redirect_pc = 32'd0;
    if (commit_now) begin
      case (kind[head])
        ROB_KIND_BRANCH: begin
          flush_now   = (taken != pred[head]);
          redirect_pc = branch_redirect(taken, pc[head], target[head]);
        end
        ROB_KIND_JALR: begin
          flush_now   = 1'b1;
          redirect_pc = new_pc[head] & ~32'd1;
        end
        default: begin
          flush_now   = 1'b0;
          redirect_pc = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_value <= 32'd0;
      flush        <= 1'b0;
      flush_pc     <= 32'd0;
    end else if (rdy_in) begin
      commit_valid <= commit_now;
      flush        <= flush_now;
      if (commit_now) begin
        commit_tag   <= head;
        commit_rd    <= (kind[head] == ROB_KIND_BRANCH) ? '0 : rd[head];
        commit_value <= value[head];
      end
      if (flush_now) begin
        flush_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        busy     <= '0;
        ready    <= '0;
      end else begin
        if (commit_now) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        if (issue_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        if (wb_fire) begin
          ready[wb_tag] <= 1'b1;
        end
        case ({issue_fire, commit_now})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; busy/ready decide whether it is meaningful.
  always_ff @(posedge clk_in) begin
    if (issue_fire) begin
      kind[tail]   <= rob_kind_e'(issue_kind);
      rd[tail]     <= issue_rd;
      pc[tail]     <= issue_pc;
      pred[tail]   <= issue_pred_taken;
      target[tail] <= issue_target;
    end
    if (wb_fire) begin
      value[wb_tag]  <= wb_value;
      new_pc[wb_tag] <= wb_new_pc;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario-driven bench: expected commits are queued when stimulus is driven
// and compared by a monitor whenever the buffer retires an instruction.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in, rdy_in;
  logic                     issue_valid;
  logic [1:0]               issue_kind;
  logic [REG_ID_BIT-1:0]    issue_rd;
  logic [31:0]              issue_pc;
  logic                     issue_pred_taken;
  logic [31:0]              issue_target;
  logic [ROB_WIDTH_BIT-1:0] issue_tag;
  logic                     full;
  logic                     wb_valid;
  logic [ROB_WIDTH_BIT-1:0] wb_tag;
  logic [31:0]              wb_value, wb_new_pc;
  logic [ROB_WIDTH_BIT-1:0] q_tag;
  logic                     q_ready;
  logic [31:0]              q_value;
  logic                     commit_valid;
  logic [ROB_WIDTH_BIT-1:0] commit_tag;
  logic [REG_ID_BIT-1:0]    commit_rd;
  logic [31:0]              commit_value;
  logic                     flush;
  logic [31:0]              flush_pc;

  typedef struct {
    logic [ROB_WIDTH_BIT-1:0] tag;
    logic [REG_ID_BIT-1:0]    rd;
    logic [31:0]              value;
    logic                     flush;
    logic [31:0]              flush_pc;
  } exp_t;

  exp_t                     sb[$];
  int                       checks = 0;
  int                       errors = 0;
  logic                     monitor_on = 1'b0;
  logic [ROB_WIDTH_BIT-1:0] model_tail = '0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_target(issue_target), .issue_tag(issue_tag), .full(full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_new_pc(wb_new_pc), .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard: every retirement must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (monitor_on && rst_n_in === 1'b1) begin
      if (commit_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_commit: got tag=%0d rd=%0d value=%h flush=%b, required no commit",
                   commit_tag, commit_rd, commit_value, flush);
        end else begin
          exp_t e;
          logic ok;
          e  = sb.pop_front();
          ok = (commit_tag === e.tag) && (commit_rd === e.rd) &&
               (commit_value === e.value) && (flush === e.flush) &&
               (!e.flush || flush_pc === e.flush_pc);
          if (!ok) begin
            errors++;
            $display("[TB] FAIL commit_contents: got tag=%0d rd=%0d value=%h flush=%b pc=%h, required tag=%0d rd=%0d value=%h flush=%b pc=%h",
                     commit_tag, commit_rd, commit_value, flush, flush_pc,
                     e.tag, e.rd, e.value, e.flush, e.flush_pc);
          end
        end
      end else if (flush !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_flush: got flush=%b without commit, required 0", flush);
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [ROB_WIDTH_BIT-1:0] tag, input logic [REG_ID_BIT-1:0] rd,
                          input logic [31:0] value, input logic fl, input logic [31:0] fpc);
    exp_t e;
    e.tag = tag; e.rd = rd; e.value = value; e.flush = fl; e.flush_pc = fpc;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    rst_n_in    = 1'b0;
    rdy_in      = 1'b1;
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    tick;
    tick;
    rst_n_in   = 1'b1;
    model_tail = '0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [REG_ID_BIT-1:0] r, input logic [31:0] p,
                       input logic pr, input logic [31:0] t);
    issue_valid = 1'b1; issue_kind = k; issue_rd = r; issue_pc = p;
    issue_pred_taken = pr; issue_target = t;
    checks++;
    if (issue_tag !== model_tail) begin
      errors++;
      $display("[TB] FAIL issue_tag: got %0d, required %0d", issue_tag, model_tail);
    end
    tick;
    issue_valid = 1'b0;
    model_tail  = model_tail + 1'b1;
  endtask

  task automatic writeback(input logic [ROB_WIDTH_BIT-1:0] tag, input logic [31:0] v,
                           input logic [31:0] npc);
    wb_valid = 1'b1; wb_tag = tag; wb_value = v; wb_new_pc = npc;
    tick;
    wb_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending commits, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    do_reset;
    monitor_on = 1'b1;
    q_tag = '0;
    #1;
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value, flush, flush_pc, full, issue_tag, q_ready}
        !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got cv=%b tag=%0d rd=%0d val=%h fl=%b fpc=%h full=%b itag=%0d qr=%b, required all zero",
               commit_valid, commit_tag, commit_rd, commit_value, flush, flush_pc, full, issue_tag, q_ready);
    end
  endtask

  task automatic test_in_order;
    do_reset;
    issue(ROB_KIND_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
    issue(ROB_KIND_ALU, 5'd2, 32'h4, 1'b0, 32'h0);
    issue(ROB_KIND_ALU, 5'd3, 32'h8, 1'b0, 32'h0);
    push_exp(3'd0, 5'd1, 32'h10, 1'b0, 32'h0);
    push_exp(3'd1, 5'd2, 32'h20, 1'b0, 32'h0);
    push_exp(3'd2, 5'd3, 32'h30, 1'b0, 32'h0);
    writeback(3'd2, 32'h30, 32'h0);
    q_tag = 3'd2;
    #1;
    checks++;
    if (q_ready !== 1'b1 || q_value !== 32'h30) begin
      errors++;
      $display("[TB] FAIL q_lookup_ready: got ready=%b value=%h, required 1 00000030", q_ready, q_value);
    end
    q_tag = 3'd0;
    #1;
    checks++;
    if (q_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL q_lookup_pending: got %b, required 0", q_ready);
    end
    writeback(3'd0, 32'h10, 32'h0);
    writeback(3'd1, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (commit_valid !== (i < 3)) begin
        errors++;
        $display("[TB] FAIL consecutive_commit%0d: got %b, required %b", i, commit_valid, i < 3);
      end
      tick;
    end
    drain(5);
  endtask

  task automatic test_full_wrap;
    do_reset;
    for (int i = 0; i < ROB_WIDTH; i++) begin
      issue(ROB_KIND_ALU, REG_ID_BIT'(i + 1), 32'(i * 4), 1'b0, 32'h0);
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_set: got %b, required 1", full);
    end
    issue_valid = 1'b1; issue_kind = ROB_KIND_ALU; issue_rd = 5'd31;
    tick;
    issue_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || issue_tag !== 3'd0) begin
      errors++;
      $display("[TB] FAIL full_drop: got full=%b tag=%0d, required 1 0", full, issue_tag);
    end
    push_exp(3'd0, 5'd1, 32'hA0, 1'b0, 32'h0);
    writeback(3'd0, 32'hA0, 32'h0);
    tick;
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_clear: got %b, required 0", full);
    end
    issue(ROB_KIND_ALU, 5'd9, 32'h40, 1'b0, 32'h0);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_after_wrap: got %b, required 1", full);
    end
    drain(5);
  endtask

  task automatic test_branch_flush;
    do_reset;
    issue(ROB_KIND_BRANCH, 5'd0, 32'h100, 1'b0, 32'h140);
    issue(ROB_KIND_ALU, 5'd5, 32'h104, 1'b0, 32'h0);
    issue(ROB_KIND_ALU, 5'd6, 32'h108, 1'b0, 32'h0);
    writeback(3'd1, 32'h55, 32'h0);
    writeback(3'd2, 32'h66, 32'h0);
    push_exp(3'd0, 5'd0, 32'h1, 1'b1, 32'h140);
    writeback(3'd0, 32'h1, 32'h0);
    issue_valid = 1'b1; issue_kind = ROB_KIND_ALU; issue_rd = 5'd7;
    tick;
    issue_valid = 1'b0;
    model_tail  = '0;
    checks++;
    if (issue_tag !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_pointers: got tag=%0d full=%b, required 0 0", issue_tag, full);
    end
    for (int t = 1; t < 4; t++) begin
      q_tag = ROB_WIDTH_BIT'(t);
      #1;
      checks++;
      if (q_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_clears_tag%0d: got %b, required 0", t, q_ready);
      end
    end
    repeat (4) tick;
    drain(2);
  endtask

  task automatic test_branch_predicted;
    do_reset;
    push_exp(3'd0, 5'd0, 32'h1, 1'b0, 32'h0);
    issue(ROB_KIND_BRANCH, 5'd0, 32'h200, 1'b1, 32'h280);
    writeback(3'd0, 32'h1, 32'h0);
    drain(5);
    push_exp(3'd1, 5'd0, 32'h0, 1'b1, 32'h204);
    issue(ROB_KIND_BRANCH, 5'd0, 32'h200, 1'b1, 32'h280);
    writeback(3'd1, 32'h0, 32'h0);
    drain(5);
    model_tail = '0;
  endtask

  task automatic test_jalr;
    do_reset;
    push_exp(3'd0, 5'd1, 32'h104, 1'b1, 32'h2000);
    issue(ROB_KIND_JALR, 5'd1, 32'h300, 1'b0, 32'h0);
    writeback(3'd0, 32'h104, 32'h2001);
    drain(5);
    model_tail = '0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    push_exp(3'd0, 5'd1, 32'h5, 1'b0, 32'h0);
    push_exp(3'd1, 5'd2, 32'h6, 1'b0, 32'h0);
    issue(ROB_KIND_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
    writeback(3'd0, 32'h5, 32'h0);
    issue(ROB_KIND_ALU, 5'd2, 32'h4, 1'b0, 32'h0);
    q_tag = 3'd1;
    #1;
    checks++;
    if (issue_tag !== 3'd2 || full !== 1'b0 || q_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL issue_with_commit: got tag=%0d full=%b qr=%b, required 2 0 0",
               issue_tag, full, q_ready);
    end
    writeback(3'd1, 32'h6, 32'h0);
    drain(5);
  endtask

  task automatic test_reset_midstream;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      issue(ROB_KIND_ALU, REG_ID_BIT'(i + 1), 32'h0, 1'b0, 32'h0);
    end
    writeback(3'd1, 32'h11, 32'h0);
    writeback(3'd0, 32'h22, 32'h0);
    rst_n_in = 1'b0;
    tick;
    rst_n_in   = 1'b1;
    model_tail = '0;
    q_tag = 3'd1;
    #1;
    checks++;
    if (commit_valid !== 1'b0 || full !== 1'b0 || issue_tag !== 3'd0 || q_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midstream_reset: got cv=%b full=%b tag=%0d qr=%b, required 0 0 0 0",
               commit_valid, full, issue_tag, q_ready);
    end
    repeat (3) tick;
  endtask

  task automatic test_pause;
    do_reset;
    issue(ROB_KIND_ALU, 5'd7, 32'h0, 1'b0, 32'h0);
    writeback(3'd0, 32'h77, 32'h0);
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_kind = ROB_KIND_ALU; issue_rd = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (commit_valid !== 1'b0 || issue_tag !== model_tail) begin
        errors++;
        $display("[TB] FAIL pause_hold%0d: got cv=%b tag=%0d, required 0 %0d",
                 i, commit_valid, issue_tag, model_tail);
      end
    end
    issue_valid = 1'b0;
    push_exp(3'd0, 5'd7, 32'h77, 1'b0, 32'h0);
    rdy_in = 1'b1;
    tick;
    checks++;
    if (commit_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_resume: got %b, required 1", commit_valid);
    end
    drain(3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    issue_kind = ROB_KIND_ALU; issue_rd = '0; issue_pc = '0; issue_pred_taken = 1'b0;
    issue_target = '0; wb_tag = '0; wb_value = '0; wb_new_pc = '0; q_tag = '0;
    issue_valid = 1'b0; wb_valid = 1'b0; rdy_in = 1'b1; rst_n_in = 1'b0;
    test_reset;
    test_in_order;
    test_full_wrap;
    test_branch_flush;
    test_branch_predicted;
    test_jalr;
    test_back_to_back;
    test_reset_midstream;
    test_pause;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
